vram_writer: RTL and testbench
==============================

Name: vram_writer

Overview:
- CPU-side VRAM write port. It is the write counterpart to the display fetch path that reads VRAM.
- CPU writes arrive through a small register window using the same select/ack handshake as the display controller registers. Each write is queued as an {address, data} pair.
- Queued pairs are drained into VRAM only while the display does not own the VRAM bus. The block sits beside the display controller on the shared VRAM address/data bus.

Parameters:
- FIFO_DEPTH, 16, entries in the write queue; power of two, at least 2.
- STROBE_CYCLES, 2, clk_main cycles vram_we_n is held low per write; at least 1.
- ADDR_W, 24, VRAM address width.

Ports:
- clk_main  in  1  system clock; all logic on the rising edge.
- reset_in  in  1  asynchronous, active-high reset.
- wr_select  in  1  active-low register-window select.
- cpu_rw  in  1  1 = read, 0 = write.
- cpu_a_bus  in  8  register offset.
- cpu_d_bus  in  8  CPU write data.
- cpu_rd_data  out  8  registered read data.
- cpu_ack  out  1  handshake acknowledge; idle high.
- vram_bus_free  in  1  1 = display is not using the VRAM bus.
- vram_a_out  out  ADDR_W  VRAM address.
- vram_d_out  out  8  VRAM write data.
- vram_drive  out  1  1 = this block drives the VRAM address/data bus.
- vram_we_n  out  1  active-low VRAM write strobe.
- fifo_empty  out  1  queue empty.
- fifo_full  out  1  queue full.

Behaviour:
- Reset values:
  - cpu_ack = 1, cpu_rd_data = 0.
  - vram_drive = 0, vram_we_n = 1, vram_a_out = 0, vram_d_out = 0.
  - FIFO empty: fifo_empty = 1, fifo_full = 0.
  - Pointer = 0, increment = 1, overflow flag = 0, FSM in IDLE.
- Handshake:
  - An access is taken when wr_select = 0 and cpu_ack = 1. On that cycle the register action executes and cpu_ack <= 0.
  - cpu_ack stays 0 while wr_select stays 0, and returns to 1 the cycle after wr_select = 1.
  - Exactly one action occurs per select assertion.
- Register map (write):
  - 0 = ptr[7:0], 1 = ptr[15:8], 2 = ptr[23:16].
  - 3 = data: push {ptr, cpu_d_bus}, then ptr <= ptr + inc, wrapping modulo 2^ADDR_W.
  - 5 = inc; an 8-bit unsigned value, zero-extended. inc = 0 repeats the same address.
  - Other offsets are ignored.
- Register map (read): cpu_rd_data is valid from the cycle after the access is taken.
  - Offsets 0–2 return the pointer bytes; 5 returns inc.
  - 4 = status: [0] empty, [1] full, [2] overflow, [7:3] = 0. Reading 4 clears overflow.
  - 3 and undefined offsets return 0.
- FIFO:
  - A push while full (judged on the pre-cycle count) is dropped, sets overflow, and leaves the pointer unchanged.
  - A push and pop in the same cycle are both performed and the count is unchanged.
  - An overflow set and a status read in the same cycle leave overflow = 1.
- Drain FSM:
  - IDLE: move to SETUP when vram_bus_free = 1 and the queue is not empty. vram_drive = 0.
  - SETUP (1 cycle): vram_drive = 1; vram_a_out/vram_d_out = head entry; vram_we_n = 1.
  - STROBE (STROBE_CYCLES cycles): vram_we_n = 0; address and data held.
  - HOLD (1 cycle): vram_we_n = 1; still driving. On exit, pop the head and go to IDLE.
  - Minimum per write: 3 + STROBE_CYCLES cycles including IDLE.
  - Back-to-back writes re-enter SETUP from IDLE on the next cycle if the conditions still hold.
- Bus loss: if vram_bus_free falls in SETUP, STROBE or HOLD:
  - Go to IDLE next cycle with vram_we_n = 1 and vram_drive = 0.
  - Do not pop. The entry is retried later; a rewrite of the same data is idempotent.
- Reset mid-operation: strobe and drive deassert immediately (asynchronously), the queue is flushed, and the pointer is cleared.
- Queue order is strictly FIFO. The CPU handshake never stalls, even while full.

Decomposition:
- Shared package vram_writer_pkg:
  - Register offsets REG_PTR_LO/MID/HI = 0/1/2, REG_DATA = 3, REG_STATUS = 4, REG_INC = 5.
  - Status bit indices.
  - FSM state encoding IDLE/SETUP/STROBE/HOLD.
- One sub-module, vram_wr_fifo:
  - Synchronous FIFO of width ADDR_W+8 and depth FIFO_DEPTH.
  - Interface: push/pop, empty/full, head data, count.

Test Plan:
- Basic write: write ptr = 0x012345, inc = 1, data 0xAA then 0xBB with vram_bus_free = 0. Two entries queue and no strobe occurs. Raise bus_free: writes go to 0x012345 = AA then 0x012346 = BB, each with we_n low for 2 cycles, then fifo_empty = 1.
- Pointer wrap: ptr = 0xFFFFFF, inc = 2, one data write. The entry is at 0xFFFFFF and the pointer reads back as 0x000001.
- Overflow: bus_free = 0; 17 data writes with DEPTH = 16. fifo_full = 1 and the 17th write is dropped. Status read = 0x06; the next status read = 0x02.
- Bus loss: drop bus_free during STROBE. we_n = 1 and drive = 0 the next cycle, and the entry remains queued. Restoring bus_free rewrites the same address/data once more, then pops.
- Handshake: hold wr_select low for 5 cycles during a data write. Exactly one push occurs; ack goes 0 after 1 cycle and returns to 1 one cycle after select rises.
- Reset during HOLD: assert reset_in. Drive and we_n deassert without waiting for a clock; the queue is empty and the pointer reads 0.

Source files
------------

// File: rtl/vram_writer_pkg.sv
// vram_writer_pkg
// Shared definitions for the CPU-side VRAM write port: register window
// offsets, status byte bit positions and the drain state machine encoding.
package vram_writer_pkg;

    // Register window offsets (cpu_a_bus)
    localparam logic [7:0] REG_PTR_LO  = 8'd0;
    localparam logic [7:0] REG_PTR_MID = 8'd1;
    localparam logic [7:0] REG_PTR_HI  = 8'd2;
    localparam logic [7:0] REG_DATA    = 8'd3;
    localparam logic [7:0] REG_STATUS  = 8'd4;
    localparam logic [7:0] REG_INC     = 8'd5;

    // Status byte bit positions; the remaining bits read as zero
    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_OVF   = 2;

    // Drain state machine
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } drain_state_e;

endpackage

// File: rtl/vram_wr_fifo.sv
// vram_wr_fifo
// Synchronous FIFO holding queued {address, data} VRAM writes.
// Ports:
//   clk, rst     clock and asynchronous active-high reset (flushes the queue)
//   push         write push_data at the tail (ignored when full)
//   push_data    entry to enqueue
//   pop          discard the head entry (ignored when empty)
//   head_data    current head entry
//   empty, full  occupancy flags
//   count        number of entries held
module vram_wr_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    // Full is judged on the registered count, so a push into a full queue is
    // dropped even if a pop frees a slot in the same cycle.
    always_comb begin
        do_push  = push && (count_q != FULL_CNT);
        do_pop   = pop && (count_q != '0);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    assign count     = count_q;

endmodule

// File: rtl/vram_writer.sv
// vram_writer
// CPU-side VRAM write port. CPU writes through a small register window are
// queued as {address, data} pairs and drained onto the shared VRAM bus only
// while the display is not using it.
// Ports:
//   clk_main, reset_in       clock and asynchronous active-high reset
//   wr_select, cpu_rw        active-low select, 1 = read / 0 = write
//   cpu_a_bus, cpu_d_bus     register offset and write data
//   cpu_rd_data, cpu_ack     registered read data and handshake acknowledge
//   vram_bus_free            1 = display is not using the VRAM bus
//   vram_a_out, vram_d_out   VRAM address and data
//   vram_drive, vram_we_n    bus drive enable and active-low write strobe
//   fifo_empty, fifo_full    queue occupancy
module vram_writer
    import vram_writer_pkg::*;
#(
    parameter int FIFO_DEPTH    = 16,
    parameter int STROBE_CYCLES = 2,
    parameter int ADDR_W        = 24
) (
    input  logic              clk_main,
    input  logic              reset_in,
    input  logic              wr_select,
    input  logic              cpu_rw,
    input  logic [7:0]        cpu_a_bus,
    input  logic [7:0]        cpu_d_bus,
    output logic [7:0]        cpu_rd_data,
    output logic              cpu_ack,
    input  logic              vram_bus_free,
    output logic [ADDR_W-1:0] vram_a_out,
    output logic [7:0]        vram_d_out,
    output logic              vram_drive,
    output logic              vram_we_n,
    output logic              fifo_empty,
    output logic              fifo_full
);

    localparam int ENTRY_W = ADDR_W + 8;
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int SW      = $clog2(STROBE_CYCLES + 1);
    localparam logic [CW-1:0] FULL_CNT    = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] STROBE_LAST = SW'(STROBE_CYCLES - 1);

    logic               ack_q, ack_d;
    logic [7:0]         rd_data_q, rd_data_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [7:0]         inc_q, inc_d;
    logic               ovf_q, ovf_d;
    drain_state_e       state_q, state_d;
    logic [SW-1:0]      strb_cnt_q, strb_cnt_d;
    logic [ADDR_W-1:0]  vram_a_q, vram_a_d;
    logic [7:0]         vram_d_q, vram_d_d;

    logic               take;
    logic               data_wr;
    logic               push;
    logic               pop;
    logic [23:0]        ptr_bytes;
    logic [23:0]        ptr_wr;
    logic [7:0]         status;
    logic [ENTRY_W-1:0] head;
    logic               q_empty, q_full;
    logic [CW-1:0]      q_count;

    vram_wr_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_main),
        .rst       (reset_in),
        .push      (push),
        .push_data ({ptr_q, cpu_d_bus}),
        .pop       (pop),
        .head_data (head),
        .empty     (q_empty),
        .full      (q_full),
        .count     (q_count)
    );

    // The pointer is exposed as three bytes regardless of ADDR_W.
    assign ptr_bytes = 24'(ptr_q);

    always_comb begin
        status             = '0;
        status[STAT_EMPTY] = q_empty;
        status[STAT_FULL]  = q_full;
        status[STAT_OVF]   = ovf_q;
    end

    // Register window: one action per select assertion, the ack stays low
    // until select is released so a long select cannot repeat the action.
    always_comb begin
        ack_d     = ack_q;
        rd_data_d = rd_data_q;
        ptr_wr    = ptr_bytes;
        ptr_d     = ptr_q;
        inc_d     = inc_q;
        ovf_d     = ovf_q;
        data_wr   = 1'b0;
        take      = !wr_select && ack_q;
        if (take) begin
            ack_d = 1'b0;
            if (cpu_rw) begin
                case (cpu_a_bus)
                    REG_PTR_LO:  rd_data_d = ptr_bytes[7:0];
                    REG_PTR_MID: rd_data_d = ptr_bytes[15:8];
                    REG_PTR_HI:  rd_data_d = ptr_bytes[23:16];
                    REG_INC:     rd_data_d = inc_q;
                    REG_STATUS: begin
                        rd_data_d = status;
                        ovf_d     = 1'b0;
                    end
                    default:     rd_data_d = 8'h00;
                endcase
            end else begin
                case (cpu_a_bus)
                    REG_PTR_LO: begin
                        ptr_wr[7:0] = cpu_d_bus;
                        ptr_d       = ADDR_W'(ptr_wr);
                    end
                    REG_PTR_MID: begin
                        ptr_wr[15:8] = cpu_d_bus;
                        ptr_d        = ADDR_W'(ptr_wr);
                    end
                    REG_PTR_HI: begin
                        ptr_wr[23:16] = cpu_d_bus;
                        ptr_d         = ADDR_W'(ptr_wr);
                    end
                    REG_DATA:   data_wr = 1'b1;
                    REG_INC:    inc_d   = cpu_d_bus;
                    default:    ;
                endcase
            end
        end else if (wr_select) begin
            ack_d = 1'b1;
        end
        // A data write into a full queue is dropped and leaves the pointer alone.
        if (data_wr) begin
            if (q_count == FULL_CNT) begin
                ovf_d = 1'b1;
            end else begin
                ptr_d = ptr_q + ADDR_W'(inc_q);
            end
        end
    end

    assign push = data_wr && (q_count != FULL_CNT);

    // Drain FSM: the head is only popped after a complete, uninterrupted
    // SETUP/STROBE/HOLD sequence; losing the bus abandons the attempt.
    always_comb begin
        state_d    = state_q;
        strb_cnt_d = strb_cnt_q;
        vram_a_d   = vram_a_q;
        vram_d_d   = vram_d_q;
        pop        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (vram_bus_free && !q_empty) begin
                    state_d  = SETUP;
                    vram_a_d = head[ENTRY_W-1:8];
                    vram_d_d = head[7:0];
                end
            end
            SETUP: begin
                if (!vram_bus_free) begin
                    state_d = IDLE;
                end else begin
                    state_d    = STROBE;
                    strb_cnt_d = '0;
                end
            end
            STROBE: begin
                if (!vram_bus_free) begin
                    state_d = IDLE;
                end else if (strb_cnt_q == STROBE_LAST) begin
                    state_d = HOLD;
                end else begin
                    strb_cnt_d = strb_cnt_q + SW'(1);
                end
            end
            HOLD: begin
                state_d = IDLE;
                pop     = vram_bus_free;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_main or posedge reset_in) begin
        if (reset_in) begin
            ack_q      <= 1'b1;
            rd_data_q  <= '0;
            ptr_q      <= '0;
            inc_q      <= 8'd1;
            ovf_q      <= 1'b0;
            state_q    <= IDLE;
            strb_cnt_q <= '0;
            vram_a_q   <= '0;
            vram_d_q   <= '0;
        end else begin
            ack_q      <= ack_d;
            rd_data_q  <= rd_data_d;
            ptr_q      <= ptr_d;
            inc_q      <= inc_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            strb_cnt_q <= strb_cnt_d;
            vram_a_q   <= vram_a_d;
            vram_d_q   <= vram_d_d;
        end
    end

    // Decoded straight from the state register so reset releases the bus
    // without waiting for a clock edge.
    assign vram_drive  = (state_q != IDLE);
    assign vram_we_n   = (state_q != STROBE);
    assign vram_a_out  = vram_a_q;
    assign vram_d_out  = vram_d_q;
    assign cpu_ack     = ack_q;
    assign cpu_rd_data = rd_data_q;
    assign fifo_empty  = q_empty;
    assign fifo_full   = q_full;

endmodule

// File: tb/tb_vram_writer.sv
// tb_vram_writer
// Self-checking bench for vram_writer: directed scenarios plus randomized
// register traffic and bus availability, compared every cycle against a
// behavioural model of the write queue and VRAM write timing.
module tb_vram_writer;

    localparam int DEPTH = 16;
    localparam int SC    = 2;

    logic        clk_main = 1'b0;
    logic        reset_in = 1'b1;
    logic        wr_select = 1'b1;
    logic        cpu_rw = 1'b0;
    logic [7:0]  cpu_a_bus = '0;
    logic [7:0]  cpu_d_bus = '0;
    logic [7:0]  cpu_rd_data;
    logic        cpu_ack;
    logic        vram_bus_free = 1'b0;
    logic [23:0] vram_a_out;
    logic [7:0]  vram_d_out;
    logic        vram_drive;
    logic        vram_we_n;
    logic        fifo_empty;
    logic        fifo_full;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;
    bit rand_bus = 1'b0;

    vram_writer #(
        .FIFO_DEPTH    (DEPTH),
        .STROBE_CYCLES (SC),
        .ADDR_W        (24)
    ) dut (
        .clk_main      (clk_main),
        .reset_in      (reset_in),
        .wr_select     (wr_select),
        .cpu_rw        (cpu_rw),
        .cpu_a_bus     (cpu_a_bus),
        .cpu_d_bus     (cpu_d_bus),
        .cpu_rd_data   (cpu_rd_data),
        .cpu_ack       (cpu_ack),
        .vram_bus_free (vram_bus_free),
        .vram_a_out    (vram_a_out),
        .vram_d_out    (vram_d_out),
        .vram_drive    (vram_drive),
        .vram_we_n     (vram_we_n),
        .fifo_empty    (fifo_empty),
        .fifo_full     (fifo_full)
    );

    always #5 clk_main = ~clk_main;

    // Behavioural model: queue of {addr,data}, cycles elapsed in the current
    // write attempt (0 = no attempt, 1 = setup, 2..SC+1 = strobe, SC+2 = hold).
    logic [31:0] m_q[$];
    int          m_phase;
    logic [23:0] m_ptr;
    logic [7:0]  m_inc;
    logic [7:0]  m_rd;
    bit          m_ovf;
    bit          m_ack;
    int          mp_size;
    bit          mp_full, mp_empty, mp_ovf, mp_take;

    always @(posedge clk_main or posedge reset_in) begin
        if (reset_in) begin
            m_q.delete();
            m_phase = 0;
            m_ptr   = '0;
            m_inc   = 8'd1;
            m_rd    = '0;
            m_ovf   = 1'b0;
            m_ack   = 1'b1;
        end else begin
            mp_size  = m_q.size();
            mp_full  = (mp_size == DEPTH);
            mp_empty = (mp_size == 0);
            mp_ovf   = m_ovf;
            mp_take  = !wr_select && m_ack;
            if (m_phase == 0) begin
                if (vram_bus_free && !mp_empty) m_phase = 1;
            end else if (!vram_bus_free) begin
                m_phase = 0;
            end else if (m_phase == SC + 2) begin
                void'(m_q.pop_front());
                m_phase = 0;
            end else begin
                m_phase++;
            end
            if (mp_take) begin
                m_ack = 1'b0;
                if (cpu_rw) begin
                    case (cpu_a_bus)
                        8'd0: m_rd = m_ptr[7:0];
                        8'd1: m_rd = m_ptr[15:8];
                        8'd2: m_rd = m_ptr[23:16];
                        8'd5: m_rd = m_inc;
                        8'd4: begin
                            m_rd  = {5'b0, mp_ovf, mp_full, mp_empty};
                            m_ovf = 1'b0;
                        end
                        default: m_rd = 8'h00;
                    endcase
                end else begin
                    case (cpu_a_bus)
                        8'd0: m_ptr[7:0]   = cpu_d_bus;
                        8'd1: m_ptr[15:8]  = cpu_d_bus;
                        8'd2: m_ptr[23:16] = cpu_d_bus;
                        8'd5: m_inc        = cpu_d_bus;
                        8'd3: begin
                            if (mp_full) begin
                                m_ovf = 1'b1;
                            end else begin
                                m_q.push_back({m_ptr, cpu_d_bus});
                                m_ptr = m_ptr + 24'(m_inc);
                            end
                        end
                        default: ;
                    endcase
                end
            end else if (wr_select) begin
                m_ack = 1'b1;
            end
        end
    end

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk_main) begin
        if (chk_en) begin
            checkOutput("ack", 32'(cpu_ack), 32'(m_ack));
            checkOutput("rd_data", 32'(cpu_rd_data), 32'(m_rd));
            checkOutput("drive", 32'(vram_drive), 32'(m_phase != 0));
            checkOutput("we_n", 32'(vram_we_n), 32'(!(m_phase >= 2 && m_phase <= SC + 1)));
            checkOutput("empty", 32'(fifo_empty), 32'(m_q.size() == 0));
            checkOutput("full", 32'(fifo_full), 32'(m_q.size() == DEPTH));
            if (m_phase != 0 && m_q.size() > 0) begin
                checkOutput("vram_addr", 32'(vram_a_out), 32'(m_q[0][31:8]));
                checkOutput("vram_data", 32'(vram_d_out), 32'(m_q[0][7:0]));
            end
        end
    end

    // Log of VRAM write strobes as {addr,data}, and length of the last strobe.
    logic [31:0] wlog[$];
    int          low_run  = 0;
    int          last_run = 0;
    bit          prev_low = 1'b0;

    always @(negedge clk_main) begin
        if (vram_we_n === 1'b0) begin
            if (!prev_low) begin
                wlog.push_back({vram_a_out, vram_d_out});
                low_run = 0;
            end
            low_run++;
        end else if (prev_low) begin
            last_run = low_run;
        end
        prev_low = (vram_we_n === 1'b0);
    end

    task automatic tick();
        @(posedge clk_main);
        #2;
        if (rand_bus) vram_bus_free = ($urandom_range(0, 3) != 0);
    endtask

    task automatic applyStimulus(input logic rw, input logic [7:0] a, input logic [7:0] d, input int hold);
        wr_select = 1'b0;
        cpu_rw    = rw;
        cpu_a_bus = a;
        cpu_d_bus = d;
        repeat (hold) tick();
        wr_select = 1'b1;
        tick();
    endtask

    task automatic readReg(input logic [7:0] a, output logic [7:0] v);
        applyStimulus(1'b1, a, 8'h00, 1);
        v = cpu_rd_data;
    endtask

    task automatic waitDrained(input int budget);
        int n = 0;
        while (!(fifo_empty === 1'b1 && vram_drive === 1'b0) && n < budget) begin
            tick();
            n++;
        end
        checkOutput("drain_in_budget", 32'(n < budget), 32'd1);
        tick();
    endtask

    task automatic waitPhase(input int ph, input int budget);
        int n = 0;
        while (m_phase != ph && n < budget) begin
            tick();
            n++;
        end
        checkOutput("phase_in_budget", 32'(n < budget), 32'd1);
    endtask

    logic [7:0] rv;

    initial begin
        // Reset state
        repeat (3) tick();
        chk_en = 1'b1;
        checkOutput("rst_ack", 32'(cpu_ack), 32'd1);
        checkOutput("rst_rd", 32'(cpu_rd_data), 32'd0);
        checkOutput("rst_drive", 32'(vram_drive), 32'd0);
        checkOutput("rst_we_n", 32'(vram_we_n), 32'd1);
        checkOutput("rst_addr", 32'(vram_a_out), 32'd0);
        checkOutput("rst_data", 32'(vram_d_out), 32'd0);
        checkOutput("rst_empty", 32'(fifo_empty), 32'd1);
        checkOutput("rst_full", 32'(fifo_full), 32'd0);
        reset_in = 1'b0;
        tick();
        readReg(8'd5, rv);
        checkOutput("rst_inc", 32'(rv), 32'd1);

        // Basic write
        applyStimulus(1'b0, 8'd0, 8'h45, 1);
        applyStimulus(1'b0, 8'd1, 8'h23, 1);
        applyStimulus(1'b0, 8'd2, 8'h01, 1);
        applyStimulus(1'b0, 8'd5, 8'h01, 1);
        applyStimulus(1'b0, 8'd3, 8'hAA, 1);
        applyStimulus(1'b0, 8'd3, 8'hBB, 1);
        checkOutput("basic_queued", 32'(fifo_empty), 32'd0);
        checkOutput("basic_no_strobe", 32'(wlog.size()), 32'd0);
        vram_bus_free = 1'b1;
        waitDrained(40);
        checkOutput("basic_nwrites", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            checkOutput("basic_w0", wlog[0], 32'h012345AA);
            checkOutput("basic_w1", wlog[1], 32'h012346BB);
        end
        checkOutput("basic_strobe_len", 32'(last_run), 32'd2);

        // Pointer wrap
        vram_bus_free = 1'b0;
        wlog.delete();
        applyStimulus(1'b0, 8'd0, 8'hFF, 1);
        applyStimulus(1'b0, 8'd1, 8'hFF, 1);
        applyStimulus(1'b0, 8'd2, 8'hFF, 1);
        applyStimulus(1'b0, 8'd5, 8'h02, 1);
        applyStimulus(1'b0, 8'd3, 8'h5A, 1);
        readReg(8'd0, rv);
        checkOutput("wrap_ptr_lo", 32'(rv), 32'h01);
        readReg(8'd1, rv);
        checkOutput("wrap_ptr_mid", 32'(rv), 32'h00);
        readReg(8'd2, rv);
        checkOutput("wrap_ptr_hi", 32'(rv), 32'h00);
        vram_bus_free = 1'b1;
        waitDrained(20);
        checkOutput("wrap_nwrites", 32'(wlog.size()), 32'd1);
        if (wlog.size() == 1) checkOutput("wrap_w0", wlog[0], 32'hFFFFFF5A);

        // Overflow
        vram_bus_free = 1'b0;
        wlog.delete();
        for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b0, 8'd3, 8'(i), 1);
        checkOutput("ovf_full", 32'(fifo_full), 32'd1);
        readReg(8'd4, rv);
        checkOutput("ovf_status1", 32'(rv), 32'h06);
        readReg(8'd4, rv);
        checkOutput("ovf_status2", 32'(rv), 32'h02);
        readReg(8'd0, rv);
        checkOutput("ovf_ptr_kept", 32'(rv), 32'h21);
        vram_bus_free = 1'b1;
        waitDrained(DEPTH * (SC + 3) + 20);
        checkOutput("ovf_nwrites", 32'(wlog.size()), 32'(DEPTH));
        if (wlog.size() == DEPTH) begin
            checkOutput("ovf_first", wlog[0], 32'h00000100);
            checkOutput("ovf_last", wlog[DEPTH-1], 32'h00001F0F);
        end

        // Bus loss during strobe
        vram_bus_free = 1'b0;
        wlog.delete();
        applyStimulus(1'b0, 8'd3, 8'h77, 1);
        vram_bus_free = 1'b1;
        waitPhase(2, 10);
        vram_bus_free = 1'b0;
        tick();
        checkOutput("loss_drive", 32'(vram_drive), 32'd0);
        checkOutput("loss_we_n", 32'(vram_we_n), 32'd1);
        checkOutput("loss_kept", 32'(fifo_empty), 32'd0);
        repeat (3) tick();
        vram_bus_free = 1'b1;
        waitDrained(20);
        checkOutput("loss_nwrites", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            checkOutput("loss_w0", wlog[0], 32'h00002177);
            checkOutput("loss_w1", wlog[1], 32'h00002177);
        end

        // Handshake with a long select
        vram_bus_free = 1'b0;
        wlog.delete();
        wr_select = 1'b0;
        cpu_rw    = 1'b0;
        cpu_a_bus = 8'd3;
        cpu_d_bus = 8'h3C;
        tick();
        checkOutput("hs_ack_low", 32'(cpu_ack), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("hs_ack_held", 32'(cpu_ack), 32'd0);
        end
        wr_select = 1'b1;
        tick();
        checkOutput("hs_ack_back", 32'(cpu_ack), 32'd1);
        vram_bus_free = 1'b1;
        waitDrained(20);
        checkOutput("hs_one_push", 32'(wlog.size()), 32'd1);

        // Reset during HOLD
        vram_bus_free = 1'b0;
        applyStimulus(1'b0, 8'd0, 8'h10, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'd3, 8'(8'h90 + i), 1);
        vram_bus_free = 1'b1;
        waitPhase(SC + 2, 10);
        checkOutput("hold_driving", 32'(vram_drive), 32'd1);
        #1 reset_in = 1'b1;
        #1;
        checkOutput("arst_drive", 32'(vram_drive), 32'd0);
        checkOutput("arst_we_n", 32'(vram_we_n), 32'd1);
        tick();
        reset_in = 1'b0;
        tick();
        checkOutput("arst_empty", 32'(fifo_empty), 32'd1);
        readReg(8'd0, rv);
        checkOutput("arst_ptr_lo", 32'(rv), 32'h00);
        readReg(8'd1, rv);
        checkOutput("arst_ptr_mid", 32'(rv), 32'h00);
        readReg(8'd2, rv);
        checkOutput("arst_ptr_hi", 32'(rv), 32'h00);

        // Randomized traffic against the model
        rand_bus = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 15) == 0) ? 8'hC3 : 8'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) a = 8'd3;
            applyStimulus(1'($urandom_range(0, 1)), a, 8'($urandom), $urandom_range(1, 3));
            repeat ($urandom_range(0, 2)) tick();
        end
        rand_bus = 1'b0;
        vram_bus_free = 1'b1;
        waitDrained(DEPTH * (SC + 3) + 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
